// File: rtl/mod_divider.sv
// mod_divider: iterative radix-2 RV32M divide/remainder unit that stalls the front of the pipe while busy
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
module mod_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [1:0]                 op_i,
  input  logic [DATA_WIDTH-1:0]      dividend_i,
  input  logic [DATA_WIDTH-1:0]      divisor_i,
  input  logic [`REG_ADDR_WIDTH-1:0] rd_i,
  input  logic                       flush_i,
  output logic                       stall_req_o,
  output logic                       result_valid_o,
  output logic [DATA_WIDTH-1:0]      result_o,
  output logic [`REG_ADDR_WIDTH-1:0] rd_o
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [W-1:0] quot, rem, dvs, abs_a, abs_b, spec_res, quot_n, rem_n, fix_res;
  logic [W:0] rem_sh, diff;
  logic [CW-1:0] cnt;
  logic [`REG_ADDR_WIDTH-1:0] rd_q;
  logic sel_rem, qneg, rneg, accept, sgn, a_neg, b_neg, div0, ovf, ge;
  assign accept = state == IDLE && start_i && !flush_i;
  assign stall_req_o = accept || state == BUSY;
  assign result_valid_o = state == DONE && !flush_i;
  assign sgn = !op_i[0];
  assign a_neg = sgn & dividend_i[W-1];
  assign b_neg = sgn & divisor_i[W-1];
  assign abs_a = a_neg ? -dividend_i : dividend_i;
  assign abs_b = b_neg ? -divisor_i : divisor_i;
  assign div0 = divisor_i == '0;
  assign ovf = sgn && dividend_i == MIN && divisor_i == '1;
  assign spec_res = div0 ? (op_i[1] ? dividend_i : '1) : (op_i[1] ? '0 : MIN);
  assign rem_sh = {rem, quot[W-1]};
  assign diff = rem_sh - {1'b0, dvs};
  assign ge = !diff[W];
  assign rem_n = ge ? diff[W-1:0] : rem_sh[W-1:0];
  assign quot_n = {quot[W-2:0], ge};
  assign fix_res = sel_rem ? (rneg ? -rem_n : rem_n) : (qneg ? -quot_n : quot_n);
  // FSM: latch operands on accept, one restoring step per BUSY cycle, sign-fixed result registered on entry to DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      quot <= '0;
      rem <= '0;
      dvs <= '0;
      sel_rem <= 1'b0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      rd_q <= '0;
      result_o <= '0;
      rd_o <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          sel_rem <= op_i[1];
          qneg <= a_neg ^ b_neg;
          rneg <= a_neg;
          rd_q <= rd_i;
          quot <= abs_a;
          dvs <= abs_b;
          rem <= '0;
          cnt <= '0;
          if (div0 || ovf) begin
            result_o <= spec_res;
            rd_o <= rd_i;
            state <= DONE;
          end else state <= BUSY;
        end
        BUSY: if (flush_i) state <= IDLE;
        else begin
          quot <= quot_n;
          rem <= rem_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            result_o <= fix_res;
            rd_o <= rd_q;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_divider.sv
// tb_mod_divider: directed checks of mod_divider results, latency, stall, flush and reset behaviour
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
module tb_mod_divider;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic [1:0] op_i = 2'b00;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [`REG_ADDR_WIDTH-1:0] rd_i = '0;
  logic flush_i = 1'b0;
  logic stall_req_o, result_valid_o;
  logic [31:0] result_o;
  logic [`REG_ADDR_WIDTH-1:0] rd_o;
  int total = 0;
  int bad = 0;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
  mod_divider #(.DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_i(rd_i), .flush_i(flush_i),
    .stall_req_o(stall_req_o), .result_valid_o(result_valid_o), .result_o(result_o), .rd_o(rd_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                     input bit noise, input string tag);
    int lat = 0;
    int stalls;
    @(posedge clk_i); #1;
    op_i = op; dividend_i = a; divisor_i = b; rd_i = rd; start_i = 1'b1;
    @(negedge clk_i);
    stalls = int'(stall_req_o);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) begin
        @(posedge clk_i); #1;
        if (noise) begin
          start_i = (n >= 3 && n <= 8) ? (n % 2 == 1) : 1'b0;
          dividend_i = 32'hdead0000 + n;
          divisor_i = n;
          op_i = DIV;
          rd_i = 5'd31;
        end
      end
      @(negedge clk_i);
      if (result_valid_o) begin
        lat = n;
        chk({tag, "_stall_done"}, {31'd0, stall_req_o}, 32'd0);
        break;
      end
      stalls += int'(stall_req_o);
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_stalls"}, stalls, exp_lat);
    chk({tag, "_res"}, result_o, exp);
    chk({tag, "_rd"}, {27'd0, rd_o}, {27'd0, rd});
  endtask
  initial begin
    int vcnt;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_valid", {31'd0, result_valid_o}, 32'd0);
    chk("rst_res", result_o, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    @(posedge clk_i); #1;
    op_i = DIVU; dividend_i = 32'd5; divisor_i = 32'd0; start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    chk("idle_flush_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("idle_flush_valid", {31'd0, result_valid_o}, 32'd0);
    run(DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33, 1'b0, "divu_100_7");
    run(REMU, 32'd100, 32'd7, 5'd4, 32'd2, 33, 1'b0, "remu_100_7");
    run(DIV, -32'sd7, 32'd2, 5'd5, 32'hfffffffd, 33, 1'b0, "div_m7_2");
    run(REM, -32'sd7, 32'd2, 5'd6, 32'hffffffff, 33, 1'b0, "rem_m7_2");
    run(DIV, 32'd7, -32'sd2, 5'd7, 32'hfffffffd, 33, 1'b0, "div_7_m2");
    run(REM, 32'd7, -32'sd2, 5'd8, 32'd1, 33, 1'b0, "rem_7_m2");
    run(DIV, 32'h80000000, 32'd2, 5'd10, 32'hc0000000, 33, 1'b0, "div_min_2");
    run(REMU, 32'hffffffff, 32'h10, 5'd11, 32'hf, 33, 1'b0, "remu_max_16");
    run(DIVU, 32'd5, 32'd0, 5'd12, 32'hffffffff, 1, 1'b0, "divu_5_0");
    run(REMU, 32'd5, 32'd0, 5'd13, 32'd5, 1, 1'b0, "remu_5_0");
    run(DIV, 32'd5, 32'd0, 5'd14, 32'hffffffff, 1, 1'b0, "div_5_0");
    run(REM, 32'h80000000, 32'hffffffff, 5'd15, 32'd0, 1, 1'b0, "rem_ovf");
    run(DIV, 32'h80000000, 32'hffffffff, 5'd16, 32'h80000000, 1, 1'b0, "div_ovf");
    run(DIVU, 32'd100, 32'd7, 5'd17, 32'd14, 33, 1'b1, "ignore_start");
    @(posedge clk_i); #1;
    op_i = DIV; dividend_i = 32'd1000; divisor_i = 32'd3; rd_i = 5'd20; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_stall_t10", {31'd0, stall_req_o}, 32'd1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_stall_t11", {31'd0, stall_req_o}, 32'd0);
    vcnt = int'(result_valid_o);
    repeat (40) begin
      @(negedge clk_i);
      vcnt += int'(result_valid_o);
    end
    chk("flush_no_valid", vcnt, 0);
    @(posedge clk_i); #1;
    op_i = DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; rd_i = 5'd9; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, result_valid_o}, 32'd0);
    chk("mid_rst_res", result_o, 32'd0);
    chk("mid_rst_rd", {27'd0, rd_o}, 32'd0);
    run(DIVU, 32'd1000, 32'd3, 5'd9, 32'd333, 33, 1'b0, "after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
